// File: rtl/ts_serial_tx.sv
// Serial MPEG-TS transmitter: byte framer -> tagged byte FIFO -> bit serializer with generated TS clock.
// Optional macro TS_TX_SYNC_CHECK_EN: drop whole packets whose start byte is not 0x47.
module ts_serial_tx #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_BITS   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ts_clk,
    output logic        ts_data,
    output logic        ts_valid,
    output logic        ts_start,
    output logic        busy,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
);
    localparam int       AW       = $clog2(FIFO_DEPTH);
    localparam logic [8:0] PER_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] PER_HALF = 9'(CLK_DIV);
    localparam logic [9:0] GAP_LAST = 10'(GAP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STALL, S_GAP} state_t;

    // ---------------- input framer ----------------
    logic [7:0] in_cnt_q, in_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       push, push_tag, pop;
    logic       fifo_full, fifo_empty;
    logic       accept;
`ifdef TS_TX_SYNC_CHECK_EN
    logic       drop_q, drop_d;
`endif

    assign in_ready = enable & ~fifo_full;
    assign accept   = in_valid & in_ready;

    always_comb begin
        in_cnt_d  = in_cnt_q;
        err_cnt_d = err_cnt_q;
        push      = 1'b0;
        push_tag  = 1'b0;
`ifdef TS_TX_SYNC_CHECK_EN
        drop_d    = drop_q;
`endif
        if (accept) begin
            if (in_cnt_q == 8'd0) begin
                // bytes without a start tag here are discarded while hunting for sync
                if (in_start) begin
                    in_cnt_d = 8'd1;
`ifdef TS_TX_SYNC_CHECK_EN
                    if (in_data != 8'h47) begin
                        drop_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        drop_d   = 1'b0;
                        push     = 1'b1;
                        push_tag = 1'b1;
                    end
`else
                    push     = 1'b1;
                    push_tag = 1'b1;
`endif
                end
            end else begin
`ifdef TS_TX_SYNC_CHECK_EN
                push = ~drop_q;
`else
                push = 1'b1;
`endif
                in_cnt_d = (in_cnt_q == 8'd187) ? 8'd0 : in_cnt_q + 8'd1;
                if (in_start && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // ---------------- byte FIFO (bit 8 = start tag) ----------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [8:0]    rd_data;

    assign fifo_full  = (fifo_cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign rd_data    = mem_q[rd_ptr_q];

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_tag, in_data};
    end

    // ---------------- serializer ----------------
    state_t      state_q, state_d;
    logic [8:0]  per_q, per_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        st_q, st_d;
    logic [7:0]  idx_q, idx_d;
    logic [9:0]  gap_q, gap_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        load, new_pkt;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        st_d      = st_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        pkt_cnt_d = pkt_cnt_q;
        load      = 1'b0;
        new_pkt   = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                load    = 1'b1;
                new_pkt = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                per_d   = '0;
                bit_d   = 3'd7;
            end
            S_SHIFT: begin
                per_d = per_q + 1'b1;
                if (per_q == PER_LAST) begin
                    per_d = '0;
                    if (bit_q != 3'd0) begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        bit_d = bit_q - 1'b1;
                    end else if (idx_q == 8'd187) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        if (GAP_BITS == 0) begin
                            // chain straight into the next packet so back-to-back timing stays exact
                            new_pkt = 1'b1;
                            load    = !fifo_empty;
                            state_d = fifo_empty ? S_IDLE : S_SHIFT;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: if (!fifo_empty) begin
                load    = 1'b1;
                state_d = S_SHIFT;
            end
            S_GAP: begin
                per_d = per_q + 1'b1;
                if (per_q == PER_LAST) begin
                    per_d = '0;
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        new_pkt = 1'b1;
                        load    = !fifo_empty;
                        state_d = fifo_empty ? S_IDLE : S_SHIFT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            sh_d  = rd_data[7:0];
            st_d  = rd_data[8];
            idx_d = (new_pkt || rd_data[8]) ? 8'd0 : idx_q + 8'd1;
            bit_d = 3'd7;
            per_d = '0;
        end
    end

    assign pop = load;

    logic ts_clk_q, ts_data_q, ts_valid_q, ts_start_q, busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt_q   <= '0;
            err_cnt_q  <= '0;
`ifdef TS_TX_SYNC_CHECK_EN
            drop_q     <= 1'b0;
`endif
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            state_q    <= S_IDLE;
            per_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            st_q       <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            pkt_cnt_q  <= '0;
            ts_clk_q   <= 1'b0;
            ts_data_q  <= 1'b0;
            ts_valid_q <= 1'b0;
            ts_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            err_cnt_q  <= err_cnt_d;
`ifdef TS_TX_SYNC_CHECK_EN
            drop_q     <= drop_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
            state_q    <= state_d;
            per_q      <= per_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            st_q       <= st_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            pkt_cnt_q  <= pkt_cnt_d;
            busy_q     <= (state_q != S_IDLE);
            // outputs follow the current state one cycle later; STALL freezes data/valid/start
            ts_clk_q   <= ((state_q == S_SHIFT) || (state_q == S_GAP)) && (per_q >= PER_HALF);
            if (state_q == S_SHIFT) begin
                ts_data_q  <= sh_q[7];
                ts_valid_q <= 1'b1;
                ts_start_q <= st_q;
            end else if (state_q != S_STALL) begin
                ts_data_q  <= 1'b0;
                ts_valid_q <= 1'b0;
                ts_start_q <= 1'b0;
            end
        end
    end

    assign ts_clk   = ts_clk_q;
    assign ts_data  = ts_data_q;
    assign ts_valid = ts_valid_q;
    assign ts_start = ts_start_q;
    assign busy     = busy_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_ts_serial_tx.sv
// Directed bench for ts_serial_tx: a passive monitor captures TS bits; one linear initial block drives and checks.
module tb_ts_serial_tx;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  in_data;
    logic        in_start;
    logic        in_valid;
    logic        in_ready;
    logic        ts_clk, ts_data, ts_valid, ts_start, busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ts_serial_tx #(.CLK_DIV(2), .GAP_BITS(16), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .in_data(in_data), .in_start(in_start), .in_valid(in_valid), .in_ready(in_ready),
        .ts_clk(ts_clk), .ts_data(ts_data), .ts_valid(ts_valid), .ts_start(ts_start),
        .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    // passive monitor: samples on the falling clk edge, records bits at ts_clk rising edges
    bit rx_bits [0:16383];
    bit rx_st   [0:16383];
    int rx_n = 0, n_pk = 0, inv_run = 0, cyc = 0;
    int pk_gap [0:15];
    int pk_t   [0:15];
    int start_cyc = 0, v_falls = 0, low_run = 0, max_low = 0;
    bit prev_clk = 0, prev_vld = 0, prev_vbit = 0;

    always @(negedge clk) begin
        cyc++;
        if (ts_start) start_cyc++;
        if (prev_vld && !ts_valid) v_falls++;
        if (ts_valid && !ts_clk) low_run++; else low_run = 0;
        if (low_run > max_low) max_low = low_run;
        if (ts_clk && !prev_clk) begin
            if (ts_valid) begin
                if (!prev_vbit && n_pk < 16) begin
                    pk_gap[n_pk] = inv_run;
                    pk_t[n_pk]   = cyc;
                    n_pk++;
                    inv_run = 0;
                end
                if (rx_n < 16384) begin
                    rx_bits[rx_n] = ts_data;
                    rx_st[rx_n]   = ts_start;
                    rx_n++;
                end
            end else begin
                inv_run++;
            end
            prev_vbit = ts_valid;
        end
        prev_clk = ts_clk;
        prev_vld = ts_valid;
    end

    byte exp_b [0:187];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pkt(input byte b0, input byte off);
        exp_b[0] = b0;
        for (int i = 1; i < 188; i++) exp_b[i] = byte'(i - 1 + off);
    endtask

    task automatic send_byte(input byte d, input bit s);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_start = s;
        while (!in_ready && t < 1000) begin @(posedge clk); #1; t++; end
        if (t >= 1000) chk("in_ready_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_start = 1'b0;
    endtask

    task automatic send_pkt(input int from, input int err_at);
        for (int i = from; i < 188; i++) send_byte(exp_b[i], (i == 0) || (i == err_at));
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (rx_n < target && t < 30000) begin @(negedge clk); t++; end
        chk("bits_timeout", 32'(rx_n >= target), 32'd1);
        t = 0;
        while (busy && t < 1000) begin @(negedge clk); t++; end
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic check_rx(input string tag, input int base);
        int bad = 0;
        byte b;
        for (int i = 0; i < 1504; i++) begin
            b = exp_b[i >> 3];
            if (rx_bits[base + i] !== b[7 - (i & 7)] || rx_st[base + i] !== (i < 8)) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    int base, sc0, vf0, np0;

    initial begin
        reset_n = 1'b0; enable = 1'b1; in_data = '0; in_start = 1'b0; in_valid = 1'b0;
        #23;
        chk("rst_ts_clk", 32'(ts_clk), 0);
        chk("rst_outs", {28'd0, ts_data, ts_valid, ts_start, busy}, 0);
        chk("rst_cnts", {8'd0, pkt_cnt, err_cnt}, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 1);

        // 1: single packet, 3-cycle latency, start width, bit-exact
        set_pkt(8'h47, 8'h00);
        in_valid = 1'b1; in_data = exp_b[0]; in_start = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0; in_start = 1'b0;
        chk("lat_c0", 32'(ts_valid), 0);
        @(posedge clk); #1; chk("lat_c1", 32'(ts_valid), 0);
        @(posedge clk); #1; chk("lat_c2", 32'(ts_valid), 0);
        @(posedge clk); #1; chk("lat_c3", {ts_valid, ts_start}, 2'b11);
        send_pkt(1, -1);
        wait_done(1504);
        check_rx("pkt1_bits", 0);
        chk("pkt1_start_cycles", 32'(start_cyc), 32);
        chk("pkt1_pkt_cnt", 32'(pkt_cnt), 1);

        // 2: three back-to-back packets
        set_pkt(8'h47, 8'h10);
        base = rx_n; np0 = n_pk;
        for (int p = 0; p < 3; p++) send_pkt(0, -1);
        wait_done(base + 3 * 1504);
        for (int p = 0; p < 3; p++) check_rx("b2b_bits", base + p * 1504);
        chk("b2b_gap1", 32'(pk_gap[np0 + 1]), 16);
        chk("b2b_gap2", 32'(pk_gap[np0 + 2]), 16);
        chk("b2b_period", 32'(pk_t[np0 + 2] - pk_t[np0 + 1]), (1504 + 16) * 4);
        chk("b2b_pkt_cnt", 32'(pkt_cnt), 4);
        chk("b2b_err_cnt", 32'(err_cnt), 0);

        // 3: input pause after byte 100 forces STALL
        chk("no_stall_yet", 32'(max_low), 2);
        set_pkt(8'h47, 8'h33);
        base = rx_n; vf0 = v_falls;
        for (int i = 0; i < 188; i++) begin
            send_byte(exp_b[i], i == 0);
            if (i == 100) repeat (700) @(posedge clk);
            #0;
        end
        wait_done(base + 1504);
        check_rx("stall_bits", base);
        chk("stall_flat_low", 32'(max_low > 100), 1);
        chk("stall_valid_falls", 32'(v_falls - vf0), 1);
        chk("stall_pkt_cnt", 32'(pkt_cnt), 5);

        // 4: five unframed bytes are dropped
        for (int i = 0; i < 5; i++) send_byte(byte'(8'hA0 + i), 1'b0);
        set_pkt(8'h47, 8'h55);
        base = rx_n;
        send_pkt(0, -1);
        wait_done(base + 1504);
        check_rx("hunt_bits", base);
        chk("hunt_len", 32'(rx_n - base), 1504);
        chk("hunt_err_cnt", 32'(err_cnt), 0);

        // 5: stray in_start mid-packet is counted but treated as data
        set_pkt(8'h47, 8'h77);
        base = rx_n;
        send_pkt(0, 50);
        wait_done(base + 1504);
        repeat (20) @(negedge clk);
        check_rx("stray_bits", base);
        chk("stray_len", 32'(rx_n - base), 1504);
        chk("stray_err_cnt", 32'(err_cnt), 1);
        chk("stray_pkt_cnt", 32'(pkt_cnt), 7);

        // 6: start byte 0x48
        set_pkt(8'h48, 8'h99);
        base = rx_n;
        send_pkt(0, -1);
`ifdef TS_TX_SYNC_CHECK_EN
        repeat (200) @(negedge clk);
        chk("badsync_none_sent", 32'(rx_n - base), 0);
        chk("badsync_err_cnt", 32'(err_cnt), 2);
        set_pkt(8'h47, 8'hC1);
        send_pkt(0, -1);
        wait_done(base + 1504);
        check_rx("after_badsync_bits", base);
`else
        wait_done(base + 1504);
        check_rx("badsync_passed_bits", base);
        chk("badsync_err_cnt", 32'(err_cnt), 1);
`endif
        chk("final_pkt_cnt", 32'(pkt_cnt), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
